relay_credit_tx: RTL
====================

Name: relay_credit_tx

Overview:
- Producer-side endpoint of a relay link, paired with a far-end receiver FIFO of depth CREDITS.
- Pulls words from a local FWFT FIFO read port and launches them onto the link (valid/data) only while it holds credits.
- Far end returns one credit pulse per word it dequeues, so no almost-full grace period is needed and link latency is unconstrained.
- Includes a flush/drain sequence so the floorplanner can quiesce or disconnect a link cleanly.

Parameters:
- DATA_WIDTH, 32, width of src_dout and link_data.
- CREDITS, 8, receiver FIFO depth; initial and maximum credit count; legal range 1..1024.
- CREDIT_WIDTH, $clog2(CREDITS+1), width of the credit counter and credits_avail (derived; do not override).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- src_empty_n  input  1  upstream FWFT FIFO has data.
- src_read  output  1  pop upstream FIFO; asserted exactly in cycles where a word is launched.
- src_dout  input  DATA_WIDTH  upstream FIFO head word.
- link_valid  output  1  one-cycle pulse per launched word.
- link_data  output  DATA_WIDTH  launched word, valid when link_valid=1.
- credit_return  input  1  one pulse = one credit returned by far end.
- flush  input  1  level request to stop launching and drain outstanding credits.
- drained  output  1  all credits home, no launches in progress.
- credits_avail  output  CREDIT_WIDTH  current credit count.
- credit_error  output  1  sticky: credit returned while counter already at CREDITS.

Behaviour:
- Reset: state=RUN, credits=CREDITS, credit_error=0, drained=0, src_read=0, link_valid=0. link_data is unreset (don't-care).
- fire = (state==RUN) & ~flush & src_empty_n & (credits != 0).
- src_read = fire, combinational. Upstream is FWFT, so src_dout is consumed in the same cycle.
- Credit counter, per cycle:
  - fire & ~credit_return: credits-1.
  - ~fire & credit_return: credits+1, saturating at CREDITS.
  - Both or neither: unchanged.
- Boundaries:
  - credits==0 blocks fire even with src_empty_n=1.
  - A return arriving at credits==0 enables fire the next cycle, not the same cycle; the credit input is registered into the counter only.
  - credit_return while credits==CREDITS and ~fire: counter holds, credit_error set. credit_error clears only on reset.
- FSM states RUN, DRAIN, DONE:
  - RUN -> DRAIN when flush=1. Fire is already suppressed in the cycle flush is first high.
  - DRAIN -> DONE when credits==CREDITS and no launch is pending in the output stage.
  - Flush deasserting during DRAIN does not abort; DRAIN still completes to DONE.
  - DONE -> RUN when flush=0.
  - drained=1 exactly while state==DONE; registered state decode.
- Output timing without the optional feature: link_valid=fire and link_data=src_dout, combinational, zero latency.
- Reset mid-operation: everything returns to reset values and in-flight credits are forgotten. The far-end receiver must be reset in the same cycle.
- Throughput: one word per cycle sustained while credits>0. A link round trip of R cycles sustains full rate iff CREDITS >= R.

Optional Feature:
- Macro RELAY_CREDIT_TX_OUTREG_EN.
- When defined:
  - link_valid and link_data are registered: link_valid <= fire; link_data <= src_dout when fire.
  - link_valid resets to 0, and there is one cycle of added launch latency.
  - The credit decrement still happens in the fire cycle.
  - DRAIN additionally waits for link_valid==0 before entering DONE.
- When undefined: combinational outputs as in Behaviour, and the DRAIN exit condition ignores the output stage.

Test Plan:
- Reset, then src_empty_n=1 held with no returns, CREDITS=8 -> exactly 8 consecutive link_valid pulses carrying upstream words in order; then link_valid=0, credits_avail=0, src_read=0.
- At credits=0, pulse credit_return once -> credits_avail=1 next cycle; one launch the following cycle; credits_avail back to 0.
- credits=4 with fire and credit_return in the same cycle for 10 cycles -> credits_avail stays 4 and 10 words launch.
- Assert flush with 3 credits outstanding, then return 3 credits over 5 cycles -> no launch after the flush cycle; drained=1 the cycle after credits reach 8; flush=0 -> RUN, and launching resumes.
- At reset state (credits=8), pulse credit_return -> credits_avail stays 8 and credit_error=1 and stays sticky; reset -> credit_error=0.
- Reset asserted mid-burst at credits=2 -> next cycle credits_avail=8, link_valid=0, state RUN. With RELAY_CREDIT_TX_OUTREG_EN, repeat the first scenario and check link_valid lags src_read by exactly 1 cycle.

Source files
------------

// File: rtl/relay_credit_tx.sv
// relay_credit_tx: producer side of a credit-based relay link.
// Pops words from a local FWFT FIFO and launches them onto the link while
// credits are held. The far end returns one credit pulse per dequeued word.
// A flush request stops launching and waits for every credit to come home,
// which lets the link be quiesced or disconnected cleanly.
// Optional build macro RELAY_CREDIT_TX_OUTREG_EN registers link_valid/link_data,
// adding one cycle of launch latency; default build drives them combinationally.
module relay_credit_tx #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int CREDITS      = 8,
  localparam int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    src_empty_n,
  output logic                    src_read,
  input  logic [DATA_WIDTH-1:0]   src_dout,
  output logic                    link_valid,
  output logic [DATA_WIDTH-1:0]   link_data,
  input  logic                    credit_return,
  input  logic                    flush,
  output logic                    drained,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic                    credit_error
);

  localparam logic [CREDIT_WIDTH-1:0] CREDITS_MAX  = CREDIT_WIDTH'(CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CREDITS_ZERO = {CREDIT_WIDTH{1'b0}};
  localparam logic [CREDIT_WIDTH-1:0] CREDITS_ONE  = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CREDIT_WIDTH-1:0] credits_r;
  logic [CREDIT_WIDTH-1:0] credits_nxt_s;
  logic                    credit_error_r;
  logic                    credit_error_nxt_s;
  logic                    drained_r;
  logic                    fire_s;
  logic                    credits_full_s;
  logic                    credits_empty_s;
  logic                    out_idle_s;

  // Credit counter status flags.
  always_comb begin
    credits_full_s  = (credits_r == CREDITS_MAX);
    credits_empty_s = (credits_r == CREDITS_ZERO);
  end

  // Launch decision: only in RUN, never while flush is requested, and only
  // with data upstream and at least one credit in hand.
  always_comb begin
    fire_s = (state_r == ST_RUN) & ~flush & src_empty_n & ~credits_empty_s;
  end

  // Next credit count and sticky overflow flag; a launch and a return in the
  // same cycle cancel out.
  always_comb begin
    credits_nxt_s      = credits_r;
    credit_error_nxt_s = credit_error_r;
    case ({fire_s, credit_return})
      2'b10: begin
        credits_nxt_s = credits_r - CREDITS_ONE;
      end
      2'b01: begin
        if (credits_full_s) begin
          credit_error_nxt_s = 1'b1;
        end else begin
          credits_nxt_s = credits_r + CREDITS_ONE;
        end
      end
      default: begin
        credits_nxt_s = credits_r;
      end
    endcase
  end

  // Flush/drain sequencing. A drain, once started, always completes even if
  // flush drops, so the far end sees a consistent quiesce.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (flush) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (credits_full_s & out_idle_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!flush) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State, credit counter, error flag and registered drained decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_RUN;
      credits_r      <= CREDITS_MAX;
      credit_error_r <= 1'b0;
      drained_r      <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      credits_r      <= credits_nxt_s;
      credit_error_r <= credit_error_nxt_s;
      drained_r      <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef RELAY_CREDIT_TX_OUTREG_EN
  logic                  link_valid_r;
  logic [DATA_WIDTH-1:0] link_data_r;

  // Registered launch strobe; the credit was already consumed in the fire cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      link_valid_r <= 1'b0;
    end else begin
      link_valid_r <= fire_s;
    end
  end

  // Registered launch data, captured only on a launch (no reset needed).
  always_ff @(posedge clk) begin
    if (fire_s) begin
      link_data_r <= src_dout;
    end else begin
      link_data_r <= link_data_r;
    end
  end

  // A word still sitting in the output stage keeps the drain from finishing.
  always_comb begin
    out_idle_s = ~link_valid_r;
    link_valid = link_valid_r;
    link_data  = link_data_r;
  end
`else
  // Zero-latency launch: the FWFT head word goes straight onto the link.
  always_comb begin
    out_idle_s = 1'b1;
    link_valid = fire_s;
    link_data  = src_dout;
  end
`endif

  // Remaining outputs.
  always_comb begin
    src_read      = fire_s;
    drained       = drained_r;
    credits_avail = credits_r;
    credit_error  = credit_error_r;
  end

endmodule
